// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the MEM-stage data-memory controller.
// Width-specific helpers assume a 32-bit word with 4 byte lanes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dmem_state_t;

  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = rd & wr;
    if (wr && f3[2]) bad = 1'b1;
    case (f3)
      F3_B, F3_BU: begin
      end
      F3_H, F3_HU: if (a[0]) bad = 1'b1;
      F3_W:        if (a != 2'b00) bad = 1'b1;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_byteen(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    b_s = word[{a, 3'b000} +: 8];
    h_s = word[{a[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    ext_s = 32'(b_s);
      F3_H:    ext_s = 32'(h_s);
      F3_BU:   ext_s = {24'd0, b_s};
      F3_HU:   ext_s = {16'd0, h_s};
      default: ext_s = word;
    endcase
    return ext_s;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge data-memory port between the MEM-stage controller (master) and memory (slave).
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_byteen;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_byteen,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_byteen,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replication, load lane extraction
// with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        fun_3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        byteen,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  assign byteen    = lane_byteen(fun_3, addr_lo);
  assign wdata_rep = lane_replicate(fun_3, wdata);
  assign rdata_ext = lane_extend(fun_3, addr_lo, mem_rdata);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: validates the EX/MEM request, runs one req/ack access,
// stalls the pipeline through busywait and aborts accesses the memory never acknowledges.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_mem_r,
  input  logic              d_mem_w,
  input  logic [2:0]        fun_3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busywait,
  output logic [DATA_W-1:0] rdata,
  output logic              access_err,
  output logic              timeout_err,
  dmem_access_ctrl_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic [3:0]        byteen;
  logic [DATA_W-1:0] wdata_rep, rdata_ext;

  logic req, illegal, accept, reject, ack_hit, to_hit;

  assign req     = d_mem_r | d_mem_w;
  assign illegal = req_illegal(d_mem_r, d_mem_w, fun_3, addr[1:0]);
  assign accept  = (state_q == ST_IDLE) && req && !illegal;
  assign reject  = (state_q == ST_IDLE) && req && illegal;
  assign ack_hit = (state_q == ST_ACCESS) && mem.mem_ack;
  assign to_hit  = (state_q == ST_ACCESS) && !mem.mem_ack && (cnt_q == CNT_LAST);

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .fun_3     (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .mem_rdata (mem.mem_rdata),
    .byteen    (byteen),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // DONE always returns to IDLE so a request still held by the pipeline is not reissued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: if (ack_hit || to_hit) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The IDLE term is combinational so the pipeline freezes in the cycle the request appears.
  always_comb begin
    busywait = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE:   busywait = accept;
        ST_ACCESS: busywait = 1'b1;
        default:   busywait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rdata       <= '0;
      access_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      access_err  <= reject;
      timeout_err <= to_hit;
      if (accept) begin
        rd_q  <= d_mem_r;
        wr_q  <= d_mem_w;
        cnt_q <= '0;
      end else if (ack_hit || to_hit) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Ack takes priority over timeout when both land in the same cycle.
      if (ack_hit && rd_q) rdata <= rdata_ext;
      else if (to_hit)     rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      f3_q    <= fun_3;
    end
  end

  assign mem.mem_read   = rd_q;
  assign mem.mem_write  = wr_q;
  assign mem.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata  = wdata_rep;
  assign mem.mem_byteen = byteen;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed table-driven bench for dmem_access_ctrl plus hand sequences for reset and timeout corners.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int TO = 64;

  logic        clk;
  logic        reset;
  logic        d_mem_r, d_mem_w;
  logic [2:0]  fun_3;
  logic [31:0] addr, wdata;
  logic        busywait;
  logic [31:0] rdata;
  logic        access_err, timeout_err;

  dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_mem_r     (d_mem_r),
    .d_mem_w     (d_mem_w),
    .fun_3       (fun_3),
    .addr        (addr),
    .wdata       (wdata),
    .busywait    (busywait),
    .rdata       (rdata),
    .access_err  (access_err),
    .timeout_err (timeout_err),
    .mem         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          ack_after;
    int          exp_bw;
    logic        exp_aerr;
    logic        exp_terr;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    int bw, rdc, wrc, aerr, terr, scnt, exp_sc;
    logic [3:0]  be;
    logic [31:0] ma, wd;
    bit done;
    bw = 0; rdc = 0; wrc = 0; aerr = 0; terr = 0; scnt = 0;
    be = '0; ma = '0; wd = '0; done = 0;
    d_mem_r = v.rd; d_mem_w = v.wr; fun_3 = v.f3; addr = v.addr; wdata = v.wd;
    bus.mem_rdata = v.mrd; bus.mem_ack = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (busywait)    bw++;
      if (access_err)  aerr++;
      if (timeout_err) terr++;
      if (bus.mem_read || bus.mem_write) begin
        if (bus.mem_read)  rdc++;
        if (bus.mem_write) wrc++;
        if (scnt == 0) begin
          be = bus.mem_byteen; ma = bus.mem_addr; wd = bus.mem_wdata;
        end
        scnt++;
        bus.mem_ack = (v.ack_after != 0) && (scnt == v.ack_after);
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (!busywait) done = 1;
      @(negedge clk);
    end
    d_mem_r = 1'b0; d_mem_w = 1'b0; bus.mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (busywait)    bw++;
      if (access_err)  aerr++;
      if (timeout_err) terr++;
      if (bus.mem_read)  rdc++;
      if (bus.mem_write) wrc++;
      @(negedge clk);
    end
    exp_sc = (v.exp_bw > 0) ? v.exp_bw - 1 : 0;
    chk({tag, " completion"}, 32'(done), 32'd1);
    chk({tag, " busywait cycles"}, bw, v.exp_bw);
    chk({tag, " access_err pulses"}, aerr, 32'(v.exp_aerr));
    chk({tag, " timeout_err pulses"}, terr, 32'(v.exp_terr));
    chk({tag, " mem_read cycles"}, rdc, v.rd ? exp_sc : 0);
    chk({tag, " mem_write cycles"}, wrc, v.wr ? exp_sc : 0);
    if (v.exp_bw > 0) begin
      chk({tag, " byteen"}, 32'(be), 32'(v.exp_be));
      chk({tag, " mem_addr"}, ma, v.exp_addr);
      if (v.wr) chk({tag, " mem_wdata"}, wd, v.exp_wd);
    end
    chk({tag, " rdata"}, rdata, v.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b1; d_mem_r = 1'b0; d_mem_w = 1'b0; fun_3 = 3'b000;
    addr = '0; wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset busywait", 32'(busywait), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("reset flags", 32'({access_err, timeout_err}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    //        rd wr f3     addr         wd            mrd           ack bw  ae te be       exp_addr     exp_wd        exp_rdata
    vt[0]  = '{1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 3,  4,  0, 0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF};
    vt[1]  = '{1, 0, F3_B,  32'h103, 32'h0,        32'h80123456, 1,  2,  0, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1, 0, F3_BU, 32'h103, 32'h0,        32'h80123456, 1,  2,  0, 0, 4'b1000, 32'h100, 32'h0,        32'h00000080};
    vt[3]  = '{0, 1, F3_H,  32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1,  2,  0, 0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h00000080};
    vt[4]  = '{1, 0, F3_W,  32'h101, 32'h0,        32'h11111111, 1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h00000080};
    vt[5]  = '{1, 0, F3_H,  32'h102, 32'h0,        32'h80017FFF, 1,  2,  0, 0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001};
    vt[6]  = '{1, 0, F3_HU, 32'h100, 32'h0,        32'h1234F00D, 1,  2,  0, 0, 4'b0011, 32'h100, 32'h0,        32'h0000F00D};
    vt[7]  = '{1, 0, F3_B,  32'h101, 32'h0,        32'h00007F00, 1,  2,  0, 0, 4'b0010, 32'h100, 32'h0,        32'h0000007F};
    vt[8]  = '{0, 1, F3_B,  32'h101, 32'h000000A5, 32'h0,        1,  2,  0, 0, 4'b0010, 32'h100, 32'hA5A5A5A5, 32'h0000007F};
    vt[9]  = '{0, 1, F3_W,  32'h104, 32'hCAFEF00D, 32'h0,        2,  3,  0, 0, 4'b1111, 32'h104, 32'hCAFEF00D, 32'h0000007F};
    vt[10] = '{1, 0, F3_H,  32'h103, 32'h0,        32'h22222222, 1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[11] = '{1, 0, 3'b011,32'h100, 32'h0,        32'h33333333, 1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[12] = '{0, 1, F3_BU, 32'h100, 32'h12,       32'h0,        1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[13] = '{1, 1, F3_W,  32'h100, 32'h0,        32'h44444444, 1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[14] = '{0, 1, F3_W,  32'h102, 32'h55,       32'h0,        1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[15] = '{1, 0, 3'b111,32'h100, 32'h0,        32'h66666666, 1,  0,  1, 0, 4'b0000, 32'h0,   32'h0,        32'h0000007F};
    vt[16] = '{1, 0, F3_B,  32'h102, 32'h0,        32'h00C30000, 5,  6,  0, 0, 4'b0100, 32'h100, 32'h0,        32'hFFFFFFC3};
    vt[17] = '{1, 0, F3_W,  32'h108, 32'h0,        32'h77777777, 0,  TO + 1, 0, 1, 4'b1111, 32'h108, 32'h0,    32'h00000000};
    vt[18] = '{1, 0, F3_W,  32'h10C, 32'h0,        32'h13579BDF, 1,  2,  0, 0, 4'b1111, 32'h10C, 32'h0,        32'h13579BDF};

    for (int i = 0; i < 19; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of an access that never receives its ack.
    d_mem_r = 1'b1; d_mem_w = 1'b0; fun_3 = F3_W; addr = 32'h110; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midreset pre mem_read", 32'(bus.mem_read), 32'd1);
    chk("midreset pre busywait", 32'(busywait), 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset mem_read", 32'(bus.mem_read), 32'd0);
    chk("midreset mem_write", 32'(bus.mem_write), 32'd0);
    chk("midreset busywait", 32'(busywait), 32'd0);
    chk("midreset rdata", rdata, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    reset = 1'b1; d_mem_r = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("late ack busywait c%0d", c), 32'(busywait), 32'd0);
      chk($sformatf("late ack mem_read c%0d", c), 32'(bus.mem_read), 32'd0);
      chk($sformatf("late ack rdata c%0d", c), rdata, 32'd0);
      chk($sformatf("late ack flags c%0d", c), 32'({access_err, timeout_err}), 32'd0);
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    v = '{1, 0, F3_W, 32'h114, 32'h0, 32'h0BADF00D, 1, 2, 0, 0, 4'b1111, 32'h114, 32'h0, 32'h0BADF00D};
    run_vec(v, "post-reset LW");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
